// File: rtl/mem_bus_master_if.sv
// Request/response handshake plus the narrow 10-bit memory bus, bundled for the bus master.
// The master modport is the initiator's view; slave is the core + memory side.
interface mem_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [9:0]  req_addr;
    logic [11:0] req_wdata;
    logic        resp_valid;
    logic [11:0] resp_rdata;
    logic        resp_err;
    logic        read_write;
    logic        write_commit;
    logic        dump_mem;
    logic [9:0]  addr_data;
    logic [11:0] mem_result;

    modport master (
        input  req_valid,
        output req_ready,
        input  req_op,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        output resp_rdata,
        output resp_err,
        output read_write,
        output write_commit,
        output dump_mem,
        output addr_data,
        input  mem_result
    );

    modport slave (
        output req_valid,
        input  req_ready,
        output req_op,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        input  resp_rdata,
        input  resp_err,
        input  read_write,
        input  write_commit,
        input  dump_mem,
        input  addr_data,
        output mem_result
    );
endinterface

// File: rtl/mem_bus_master.sv
// Initiator for the 1024x12 memory bus: turns one read/write/dump/no-op request at a time
// into the matching bus sequence and returns exactly one response pulse per request.
module mem_bus_master #(
    parameter bit VERIFY_WRITES = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WA,
        WLO,
        WHI,
        VRD,
        DUMP,
        RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;

    state_t      state;
    state_t      next_state;
    logic [9:0]  addr_q;
    logic [11:0] wdata_q;
    logic        accept;
    logic [9:0]  cur_addr;
    logic [11:0] cur_wdata;

    logic        nxt_read_write;
    logic        nxt_write_commit;
    logic        nxt_dump_mem;
    logic [9:0]  nxt_addr_data;
    logic        nxt_resp_valid;
    logic [11:0] nxt_resp_rdata;
    logic        nxt_resp_err;

    assign bus.req_ready = (state == IDLE);
    assign accept        = bus.req_valid && (state == IDLE);

    // Bus registers are loaded on the acceptance edge, before the fields are latched.
    assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OP_READ:  next_state = RD;
                        OP_WRITE: next_state = WA;
                        OP_DUMP:  next_state = DUMP;
                        default:  next_state = RESP;
                    endcase
                end
            end
            RD:      next_state = RESP;
            WA:      next_state = WLO;
            WLO:     next_state = WHI;
            WHI:     next_state = VERIFY_WRITES ? VRD : RESP;
            VRD:     next_state = RESP;
            DUMP:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus values are decoded from the state being entered so they appear registered.
    always_comb begin
        nxt_read_write   = 1'b1;
        nxt_write_commit = 1'b0;
        nxt_dump_mem     = 1'b0;
        nxt_addr_data    = 10'h000;
        case (next_state)
            RD, VRD: begin
                nxt_addr_data = cur_addr;
            end
            WA: begin
                nxt_read_write = 1'b0;
                nxt_addr_data  = cur_addr;
            end
            WLO: begin
                nxt_read_write   = 1'b0;
                nxt_write_commit = 1'b1;
                nxt_addr_data    = {3'b000, 1'b0, cur_wdata[5:0]};
            end
            WHI: begin
                nxt_read_write   = 1'b0;
                nxt_write_commit = 1'b1;
                nxt_addr_data    = {3'b000, 1'b1, cur_wdata[11:6]};
            end
            DUMP: begin
                nxt_dump_mem = 1'b1;
            end
            default: begin
                nxt_read_write = 1'b1;
            end
        endcase
    end

    always_comb begin
        nxt_resp_valid = (next_state == RESP);
        nxt_resp_rdata = 12'h000;
        nxt_resp_err   = 1'b0;
        case (state)
            RD: begin
                nxt_resp_rdata = bus.mem_result;
            end
            VRD: begin
                nxt_resp_rdata = bus.mem_result;
                nxt_resp_err   = (bus.mem_result != wdata_q);
            end
            WHI: begin
                nxt_resp_rdata = wdata_q;
            end
            default: begin
                nxt_resp_rdata = 12'h000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q           <= 10'h000;
            wdata_q          <= 12'h000;
            bus.read_write   <= 1'b1;
            bus.write_commit <= 1'b0;
            bus.dump_mem     <= 1'b0;
            bus.addr_data    <= 10'h000;
            bus.resp_valid   <= 1'b0;
            bus.resp_rdata   <= 12'h000;
            bus.resp_err     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            bus.read_write   <= nxt_read_write;
            bus.write_commit <= nxt_write_commit;
            bus.dump_mem     <= nxt_dump_mem;
            bus.addr_data    <= nxt_addr_data;
            bus.resp_valid   <= nxt_resp_valid;
            if (nxt_resp_valid) begin
                bus.resp_rdata <= nxt_resp_rdata;
                bus.resp_err   <= nxt_resp_err;
            end
        end
    end

    // Protocol invariants: commits only in the write phase, dump is a read-type cycle.
    a_commit_in_write_phase: assert property (
        @(posedge clk) disable iff (rst) bus.write_commit |-> !bus.read_write);
    a_dump_is_read: assert property (
        @(posedge clk) disable iff (rst) bus.dump_mem |-> bus.read_write);
    a_resp_single_pulse: assert property (
        @(posedge clk) disable iff (rst) bus.resp_valid |=> !bus.resp_valid);

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator side of the narrow 10-bit memory bus (`read_write`, `write_commit`, `dump_mem`, `addr_data`, `mem_result`). Converts one-at-a-time 12-bit read, write, dump and no-op requests from the core into the bus sequences the 1024x12 memory responds to, and returns one response per request. Sits between the datapath/control and the memory; it is the only driver of the memory bus.

## Interface
Parameters:
- `VERIFY_WRITES`, default 0: when 1, every write is followed by a read-back of the same address and compared.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; transfer when `req_valid & req_ready`
- `req_op`  in  2  00 read, 01 write, 10 dump, 11 no-op
- `req_addr`  in  10  word address
- `req_wdata`  in  12  write data
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  12  read data (read), written/read-back data (write), 0 (dump, no-op)
- `resp_err`  out  1  valid with `resp_valid`; write read-back mismatch (`VERIFY_WRITES`=1 only)
- `read_write`  out  1  bus: 1 = read, 0 = address/commit phase
- `write_commit`  out  1  bus: commit half-word
- `dump_mem`  out  1  bus: dump memory image
- `addr_data`  out  10  bus: address, or {3'b0, hi_sel, half[5:0]} on commit
- `mem_result`  in  12  bus: combinational read data from memory

## Operation
- All bus outputs and response outputs are registered; `req_ready` is decoded from state.
- Bus idle value: `read_write`=1, `write_commit`=0, `dump_mem`=0, `addr_data`=0 (harmless read of word 0). Never drive `read_write`=0 with `write_commit`=1 outside WLO/WHI.
- Request fields are latched on acceptance; inputs are ignored until the next IDLE.
- States: IDLE, RD, WA, WLO, WHI, VRD, DUMP, RESP.
- IDLE: accept; read -> RD, write -> WA, dump -> DUMP, no-op -> RESP.
- RD: bus `read_write`=1, `addr_data`=addr; capture `mem_result` at cycle end -> RESP.
- WA: `read_write`=0, `write_commit`=0, `addr_data`=addr (memory latches write address) -> WLO.
- WLO: `read_write`=0, `write_commit`=1, `addr_data`={3'b000,1'b0,wdata[5:0]} -> WHI.
- WHI: same, `addr_data`={3'b000,1'b1,wdata[11:6]} -> VRD if `VERIFY_WRITES` else RESP.
- VRD: read of addr; capture `mem_result`; `resp_err` = (captured != wdata) -> RESP.
- DUMP: `dump_mem`=1 for exactly one cycle, `read_write`=1 -> RESP.
- RESP: `resp_valid`=1 one cycle, bus idle -> IDLE.
- `resp_err` is 0 for all responses except a mismatching verified write.

## Timing
- Reset: state IDLE; `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, bus at idle value, all on the first edge with `rst` high.
- Acceptance in cycle 0. Bus phase cycles from cycle 1.
- Read: bus cycle 1, `resp_valid` cycle 2, `req_ready` again cycle 3.
- Write: WA/WLO/WHI cycles 1-3, `resp_valid` cycle 4 (cycle 5 with verify; VRD in cycle 4 sees the cycle-3 commit).
- Dump: `dump_mem` cycle 1, `resp_valid` cycle 2. No-op: `resp_valid` cycle 1.
- Max throughput: one request per 3 (read/dump), 5/6 (write), 2 (no-op) cycles.
- `req_valid` while not ready: held off, no side effects.
- Reset mid-write: sequence aborts; bus returns to idle on the reset edge; no response. A word may hold only the new low half; the requester owns retry.
- Address 1023 and 0 need no special handling; no wrap logic (single word per request).

## Test plan
- Reset, then idle 5 cycles -> `req_ready`=1, `read_write`=1, `write_commit`=0, `dump_mem`=0, no `resp_valid`.
- Write 0xABC to addr 0x155, then read 0x155 -> bus shows addr 0x155, then 0x03C, then 0x06A; read `resp_valid` cycle 2 with `resp_rdata`=0xABC.
- `VERIFY_WRITES`=1, write 0xFFF to 0x3FF -> `resp_valid` cycle 5, `resp_rdata`=0xFFF, `resp_err`=0; force memory model high-half stuck at 0 -> `resp_err`=1, `resp_rdata`=0x03F.
- Dump request -> `dump_mem` high exactly cycle 1, `resp_valid` cycle 2, `resp_rdata`=0.
- `req_valid` held high with alternating read/write ops -> one response per accepted request, `req_ready` low throughout each sequence, latencies per Timing.
- Assert `rst` during WLO of a write of 0x123 to 0x010 -> next cycle bus idle, no response; read 0x010 after reset returns the memory's reset-time contents (low half only if commit landed).
